// File: rtl/bullet_pool.sv
// Five-slot player bullet pool: lowest-free-slot allocation on fire, per-tick upward motion, retire at top edge or on hit.
// Optional shot cooldown is enabled by defining BULLET_COOLDOWN_EN.
module bullet_pool #(
  parameter int XW        = 10,
  parameter int YW        = 10,
  parameter int SPEED     = 4,
  parameter int SPAWN_OFF = 8,
  parameter int COOLDOWN  = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            tick,
  input  logic            fire,
  input  logic [XW-1:0]   player_x,
  input  logic [YW-1:0]   player_y,
  input  logic [4:0]      hit,
  output logic [4:0]      isBullet,
  output logic [5*XW-1:0] bullet_x,
  output logic [5*YW-1:0] bullet_y,
  output logic            fire_ack,
  output logic            fire_drop
);

  localparam int N = 5;

  logic [N-1:0]  active_q, active_d;
  logic [XW-1:0] x_q [N];
  logic [XW-1:0] x_d [N];
  logic [YW-1:0] y_q [N];
  logic [YW-1:0] y_d [N];
  logic          fire_ack_q, fire_ack_d;
  logic          fire_drop_q, fire_drop_d;

  logic [2:0]    alloc_idx;
  logic          any_free;
  logic          spawn_ok;
  logic          cd_ok;
  logic          accept;

`ifdef BULLET_COOLDOWN_EN
  localparam int CDW = ($clog2(COOLDOWN + 1) > 4) ? $clog2(COOLDOWN + 1) : 4;
  logic [CDW-1:0] cd_q, cd_d;

  assign cd_ok = (cd_q == '0);

  // A load on an accepted shot takes precedence over the tick decrement.
  always_comb begin
    cd_d = cd_q;
    if (accept)
      cd_d = CDW'(COOLDOWN);
    else if (tick && (cd_q != '0))
      cd_d = cd_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) cd_q <= '0;
    else       cd_q <= cd_d;
  end
`else
  logic cooldown_unused;
  assign cooldown_unused = (COOLDOWN != 0);
  assign cd_ok = 1'b1;
`endif

  // Allocation looks only at the registered mask; slots freed this cycle wait a cycle.
  always_comb begin
    alloc_idx = 3'd0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!active_q[i]) alloc_idx = 3'(i);
    end
  end

  assign any_free = ~&active_q;
  assign spawn_ok = (player_y >= YW'(SPAWN_OFF));
  assign accept   = fire && any_free && spawn_ok && cd_ok;

  always_comb begin
    fire_ack_d  = accept;
    fire_drop_d = fire && !accept;
    active_d    = active_q;
    for (int i = 0; i < N; i++) begin
      x_d[i] = x_q[i];
      y_d[i] = y_q[i];
      if (hit[i] && active_q[i]) begin
        active_d[i] = 1'b0;
        x_d[i]      = '0;
        y_d[i]      = '0;
      end else if (accept && (alloc_idx == 3'(i))) begin
        active_d[i] = 1'b1;
        x_d[i]      = player_x;
        y_d[i]      = player_y - YW'(SPAWN_OFF);
      end else if (tick && active_q[i]) begin
        if (y_q[i] >= YW'(SPEED)) begin
          y_d[i] = y_q[i] - YW'(SPEED);
        end else begin
          active_d[i] = 1'b0;
          x_d[i]      = '0;
          y_d[i]      = '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      active_q    <= '0;
      fire_ack_q  <= 1'b0;
      fire_drop_q <= 1'b0;
      for (int i = 0; i < N; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
      end
    end else begin
      active_q    <= active_d;
      fire_ack_q  <= fire_ack_d;
      fire_drop_q <= fire_drop_d;
      for (int i = 0; i < N; i++) begin
        x_q[i] <= x_d[i];
        y_q[i] <= y_d[i];
      end
    end
  end

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_pack
      assign bullet_x[gi*XW +: XW] = x_q[gi];
      assign bullet_y[gi*YW +: YW] = y_q[gi];
    end
  endgenerate

  assign isBullet  = active_q;
  assign fire_ack  = fire_ack_q;
  assign fire_drop = fire_drop_q;

endmodule

// File: tb/tb_bullet_pool.sv
// Self-checking bench for bullet_pool: directed table, hand sequences, and randomized run against a slot-level model.
module tb_bullet_pool;
  localparam int XW = 10, YW = 10, SPEED = 4, SPAWN_OFF = 8, COOLDOWN = 6;
`ifdef BULLET_COOLDOWN_EN
  localparam int GAP = COOLDOWN;
`else
  localparam int GAP = 0;
`endif

  logic clk = 1'b0;
  logic reset, tick, fire;
  logic [XW-1:0] player_x;
  logic [YW-1:0] player_y;
  logic [4:0] hit;
  logic [4:0] isBullet;
  logic [5*XW-1:0] bullet_x;
  logic [5*YW-1:0] bullet_y;
  logic fire_ack, fire_drop;

  bullet_pool #(.XW(XW), .YW(YW), .SPEED(SPEED), .SPAWN_OFF(SPAWN_OFF), .COOLDOWN(COOLDOWN)) dut (
    .clk(clk), .reset(reset), .tick(tick), .fire(fire),
    .player_x(player_x), .player_y(player_y), .hit(hit),
    .isBullet(isBullet), .bullet_x(bullet_x), .bullet_y(bullet_y),
    .fire_ack(fire_ack), .fire_drop(fire_drop)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int step_no = 0;

  // Slot-level reference state
  bit m_act [5];
  int m_x [5];
  int m_y [5];
  bit m_ack, m_drop;
  int m_cd;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s step=%0d got=%h exp=%h", name, step_no, got, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit t, input bit f, input int px, input int py, input bit [4:0] h);
    int slot;
    bit ok;
    if (r) begin
      for (int i = 0; i < 5; i++) begin m_act[i] = 0; m_x[i] = 0; m_y[i] = 0; end
      m_ack = 0; m_drop = 0; m_cd = 0;
      return;
    end
    slot = -1;
    for (int i = 0; i < 5; i++) if (!m_act[i] && slot < 0) slot = i;
    ok = f && (slot >= 0) && (py >= SPAWN_OFF);
`ifdef BULLET_COOLDOWN_EN
    ok = ok && (m_cd == 0);
`endif
    m_ack = ok;
    m_drop = f && !ok;
    for (int i = 0; i < 5; i++) begin
      if (h[i] && m_act[i]) begin
        m_act[i] = 0; m_x[i] = 0; m_y[i] = 0;
      end else if (ok && i == slot) begin
        m_act[i] = 1; m_x[i] = px; m_y[i] = py - SPAWN_OFF;
      end else if (t && m_act[i]) begin
        if (m_y[i] >= SPEED) m_y[i] = m_y[i] - SPEED;
        else begin m_act[i] = 0; m_x[i] = 0; m_y[i] = 0; end
      end
    end
    if (ok) m_cd = COOLDOWN;
    else if (t && m_cd > 0) m_cd = m_cd - 1;
  endtask

  task automatic compare_model();
    logic [4:0] e_isb;
    logic [5*XW-1:0] e_bx;
    logic [5*YW-1:0] e_by;
    for (int i = 0; i < 5; i++) begin
      e_isb[i] = m_act[i];
      e_bx[i*XW +: XW] = XW'(m_x[i]);
      e_by[i*YW +: YW] = YW'(m_y[i]);
    end
    check("model_isb", {57'd0, isBullet, fire_ack, fire_drop}, {57'd0, e_isb, m_ack, m_drop});
    check("model_x", {14'd0, bullet_x}, {14'd0, e_bx});
    check("model_y", {14'd0, bullet_y}, {14'd0, e_by});
  endtask

  // One clock: drive, let the DUT sample, advance the model, compare off the edge.
  task automatic step(input bit r, input bit t, input bit f, input int px, input int py, input bit [4:0] h);
    reset = r; tick = t; fire = f; player_x = XW'(px); player_y = YW'(py); hit = h;
    @(posedge clk);
    #1;
    step_no++;
    model_step(r, t, f, px, py, h);
    compare_model();
  endtask

  task automatic idle_ticks(input int n);
    for (int k = 0; k < n; k++) step(0, 1, 0, 0, 0, 5'b0);
  endtask

  typedef struct {
    bit r, t, f;
    int px, py;
    bit [4:0] h;
    bit [4:0] e_isb;
    bit e_ack, e_drop;
    int slot, ex, ey;
  } vec_t;

  vec_t tbl [18];

  initial begin
    reset = 1; tick = 0; fire = 0; player_x = '0; player_y = '0; hit = '0;

`ifndef BULLET_COOLDOWN_EN
    //           r t f  px  py   hit       isb      ack drop slot x   y
    tbl[0]  = '{1,0,0,  0,  0, 5'b00000, 5'b00000, 0, 0, 0,  0,   0};
    tbl[1]  = '{0,0,1,100,400, 5'b00000, 5'b00001, 1, 0, 0, 100, 392};
    tbl[2]  = '{0,0,1, 50,300, 5'b00000, 5'b00011, 1, 0, 1,  50, 292};
    tbl[3]  = '{0,0,1, 20, 18, 5'b00000, 5'b00111, 1, 0, 2,  20,  10};
    tbl[4]  = '{0,0,1, 30, 14, 5'b00000, 5'b01111, 1, 0, 3,  30,   6};
    tbl[5]  = '{0,0,1, 40,  8, 5'b00000, 5'b11111, 1, 0, 4,  40,   0};
    tbl[6]  = '{0,0,1,  1,500, 5'b00000, 5'b11111, 0, 1, 4,  40,   0};
    tbl[7]  = '{0,1,0,  0,  0, 5'b00000, 5'b01111, 0, 0, 3,  30,   2};
    tbl[8]  = '{0,1,0,  0,  0, 5'b00000, 5'b00111, 0, 0, 3,   0,   0};
    tbl[9]  = '{0,0,1,  5,  7, 5'b00000, 5'b00111, 0, 1, 2,  20,   2};
    tbl[10] = '{0,1,1, 60,200, 5'b00000, 5'b01011, 1, 0, 3,  60, 192};
    tbl[11] = '{0,0,1, 70,100, 5'b00000, 5'b01111, 1, 0, 2,  70,  92};
    tbl[12] = '{0,0,1, 80,100, 5'b00000, 5'b11111, 1, 0, 4,  80,  92};
    tbl[13] = '{0,0,1, 90,300, 5'b00010, 5'b11101, 0, 1, 1,   0,   0};
    tbl[14] = '{0,0,1, 90,300, 5'b00000, 5'b11111, 1, 0, 1,  90, 292};
    tbl[15] = '{0,0,0,  0,  0, 5'b11111, 5'b00000, 0, 0, 0,   0,   0};
    tbl[16] = '{0,0,1,  3,  8, 5'b00001, 5'b00001, 1, 0, 0,   3,   0};
    tbl[17] = '{0,1,0,  0,  0, 5'b00001, 5'b00000, 0, 0, 0,   0,   0};
    for (int v = 0; v < 18; v++) begin
      step(tbl[v].r, tbl[v].t, tbl[v].f, tbl[v].px, tbl[v].py, tbl[v].h);
      check($sformatf("tbl%0d_isb", v), {59'd0, isBullet}, {59'd0, tbl[v].e_isb});
      check($sformatf("tbl%0d_pulse", v), {62'd0, fire_ack, fire_drop}, {62'd0, tbl[v].e_ack, tbl[v].e_drop});
      check($sformatf("tbl%0d_x", v), {54'd0, bullet_x[tbl[v].slot*XW +: XW]}, 64'(tbl[v].ex));
      check($sformatf("tbl%0d_y", v), {54'd0, bullet_y[tbl[v].slot*YW +: YW]}, 64'(tbl[v].ey));
    end
`else
    step(1, 0, 0, 0, 0, 5'b0);
    check("rst_isb", {59'd0, isBullet}, 64'd0);
    // Cooldown: fire, 3 ticks -> drop, 3 more -> accept
    step(0, 0, 1, 100, 400, 5'b0);
    check("cd_first_ack", {63'd0, fire_ack}, 64'd1);
    idle_ticks(3);
    step(0, 0, 1, 100, 400, 5'b0);
    check("cd_early_drop", {63'd0, fire_drop}, 64'd1);
    check("cd_early_isb", {59'd0, isBullet}, 64'd1);
    idle_ticks(3);
    step(0, 0, 1, 110, 400, 5'b0);
    check("cd_late_ack", {63'd0, fire_ack}, 64'd1);
    idle_ticks(6);
    // fire+tick at zero counter loads without decrement: 5 ticks are not enough
    step(0, 1, 1, 120, 400, 5'b0);
    check("cd_ft_ack", {63'd0, fire_ack}, 64'd1);
    idle_ticks(5);
    step(0, 0, 1, 130, 400, 5'b0);
    check("cd_ft_drop", {63'd0, fire_drop}, 64'd1);
    idle_ticks(1);
    step(0, 0, 1, 130, 400, 5'b0);
    check("cd_ft_ack2", {63'd0, fire_ack}, 64'd1);
`endif

    // Reset mid-flight with three active slots and fire held
    step(1, 0, 0, 0, 0, 5'b0);
    step(0, 0, 1, 11, 400, 5'b0);
    idle_ticks(GAP);
    step(0, 0, 1, 22, 400, 5'b0);
    idle_ticks(GAP);
    step(0, 0, 1, 33, 400, 5'b0);
    check("mid_isb", {59'd0, isBullet}, 64'h7);
    step(1, 0, 1, 44, 400, 5'b0);
    check("rst_isb0", {59'd0, isBullet}, 64'd0);
    check("rst_pulse", {62'd0, fire_ack, fire_drop}, 64'd0);
    check("rst_x", {14'd0, bullet_x}, 64'd0);
    check("rst_y", {14'd0, bullet_y}, 64'd0);

    // Randomized run against the model
    for (int n = 0; n < 3000; n++) begin
      bit r, t, f;
      int py;
      bit [4:0] h;
      r = ($urandom_range(0, 299) == 0);
      t = ($urandom_range(0, 3) == 0);
      f = ($urandom_range(0, 1) == 0);
      h = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'b0;
      py = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 20) : $urandom_range(0, 479);
      step(r, t, f, $urandom_range(0, 639), py, h);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
